// File: rtl/instr_encoder.sv
// RV32 instruction encoder: decoded op fields in, 32-bit instruction words out via a small FIFO.
// Optional DIV encoding is built only when ENC_DIV_EN is defined; otherwise op 2 is illegal.
module instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [11:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     err,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_WORD = 3'b010;

    logic [31:0] enc_word;
    logic        enc_legal;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]  mem_q [DEPTH];
    logic         err_q, err_d;
    logic [7:0]   err_count_q, err_count_d;

    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;

    // Field encoder; fields not used by an op's format are simply not referenced.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (in_op)
            OP_ADD: begin
                enc_word  = {F7_BASE, in_rs2, in_rs1, F3_ADD, in_rd, OPC_REG};
                enc_legal = 1'b1;
            end
            OP_SUB: begin
                enc_word  = {F7_SUB, in_rs2, in_rs1, F3_ADD, in_rd, OPC_REG};
                enc_legal = 1'b1;
            end
`ifdef ENC_DIV_EN
            OP_DIV: begin
                enc_word  = {F7_MUL, in_rs2, in_rs1, F3_DIV, in_rd, OPC_REG};
                enc_legal = 1'b1;
            end
`endif
            OP_ADDI: begin
                enc_word  = {in_imm, in_rs1, F3_ADD, in_rd, OPC_IMM};
                enc_legal = 1'b1;
            end
            OP_LW: begin
                enc_word  = {in_imm, in_rs1, F3_WORD, in_rd, OPC_LOAD};
                enc_legal = 1'b1;
            end
            OP_SW: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OPC_STORE};
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Full is judged on registered pointers only, so a same-cycle pop never frees a slot.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = accept && !enc_legal;
        err_count_d = err_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage needs no reset: out_instr is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= enc_word;
        end
    end

    assign out_instr = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
    assign err       = err_q;
    assign err_count = err_count_q;
    assign level     = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: per-feature tasks plus a queue scoreboard of expected words.
// Works with or without ENC_DIV_EN defined.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [11:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic          err;
    logic [7:0]    err_count;
    logic [LW-1:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sb_q [$];
    logic        err_exp = 1'b0;
    int          cnt_m   = 0;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .err_count (err_count),
        .level     (level)
    );

    always #5 clk = ~clk;

    function automatic void enc_model(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [11:0] imm,
                                      output logic [31:0] w, output logic legal);
        w = 32'h0;
        legal = 1'b1;
        case (op)
            3'd0: w = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            3'd1: w = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
`ifdef ENC_DIV_EN
            3'd2: w = {7'h01, rs2, rs1, 3'b100, rd, 7'h33};
`endif
            3'd3: w = {imm, rs1, 3'b000, rd, 7'h13};
            3'd4: w = {imm, rs1, 3'b010, rd, 7'h03};
            3'd5: w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            default: legal = 1'b0;
        endcase
    endfunction

    // One clock: check state against the model, resolve the handshakes, advance the model.
    task automatic tick();
        logic [31:0] w;
        logic [31:0] e;
        logic        lg;
        bit          full_m;
        bit          acc_m;
        full_m = (sb_q.size() == DEPTH);
        n_tests++;
        if (in_ready !== !full_m)
            $display("FAIL in_ready: got %b expected %b", in_ready, !full_m);
        n_tests++;
        if (in_ready !== !full_m) n_fail++;
        if (out_valid !== (sb_q.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, sb_q.size() != 0);
        end
        n_tests++;
        if (level !== LW'(sb_q.size())) begin
            n_fail++;
            $display("FAIL level: got %0d expected %0d", level, sb_q.size());
        end
        n_tests++;
        if (err !== err_exp) begin
            n_fail++;
            $display("FAIL err: got %b expected %b", err, err_exp);
        end
        n_tests++;
        if (err_count !== 8'(cnt_m)) begin
            n_fail++;
            $display("FAIL err_count: got %0d expected %0d", err_count, cnt_m);
        end
        if (sb_q.size() != 0 && out_ready) begin
            e = sb_q.pop_front();
            n_tests++;
            if (out_instr !== e) begin
                n_fail++;
                $display("FAIL sb_word: got %h expected %h", out_instr, e);
            end
        end
        enc_model(in_op, in_rd, in_rs1, in_rs2, in_imm, w, lg);
        acc_m   = in_valid && !full_m;
        err_exp = acc_m && !lg;
        if (err_exp && cnt_m != 255) cnt_m++;
        if (acc_m && lg) sb_q.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({in_ready, out_valid, err} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, err});
        end
        n_tests++;
        if (out_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_instr: got %h expected 00000000", out_instr);
        end
        n_tests++;
        if (err_count !== 8'd0 || level !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0d/%0d expected 0/0", err_count, level);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] word;
    } vec_t;

    task automatic test_encodings();
        vec_t v [6];
        v[0] = '{op: 3'd0, rd: 5'd1, rs1: 5'd2, rs2: 5'd3, imm: 12'hABC, word: 32'h003100B3};
        v[1] = '{op: 3'd1, rd: 5'd1, rs1: 5'd2, rs2: 5'd3, imm: 12'h123, word: 32'h403100B3};
        v[2] = '{op: 3'd3, rd: 5'd5, rs1: 5'd0, rs2: 5'd31, imm: 12'hFFF, word: 32'hFFF00293};
        v[3] = '{op: 3'd4, rd: 5'd1, rs1: 5'd2, rs2: 5'd5, imm: 12'd4, word: 32'h00412083};
        v[4] = '{op: 3'd5, rd: 5'd31, rs1: 5'd2, rs2: 5'd6, imm: 12'd8, word: 32'h00612423};
        v[5] = '{op: 3'd2, rd: 5'd1, rs1: 5'd2, rs2: 5'd3, imm: 12'h0, word: 32'h023140B3};
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_op  = v[i].op;
            in_rd  = v[i].rd;
            in_rs1 = v[i].rs1;
            in_rs2 = v[i].rs2;
            in_imm = v[i].imm;
            tick();
            in_valid = 1'b0;
`ifndef ENC_DIV_EN
            if (i == 5) begin
                n_tests++;
                if (out_valid !== 1'b0 || err !== 1'b1 || err_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL div_illegal: got v=%b e=%b c=%0d expected v=0 e=1 c=1",
                             out_valid, err, err_count);
                end
            end else
`endif
            begin
                n_tests++;
                if (out_valid !== 1'b1 || out_instr !== v[i].word) begin
                    n_fail++;
                    $display("FAIL enc_%0d: got %b/%h expected 1/%h", i, out_valid, out_instr,
                             v[i].word);
                end
            end
            drain();
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_op  = 3'(i % 6 == 2 ? 0 : i % 6);
            in_rd  = 5'(i + 7);
            in_rs1 = 5'(i + 11);
            in_rs2 = 5'(i + 20);
            in_imm = 12'(i * 37 + 5);
            tick();
        end
        n_tests++;
        if (level !== LW'(DEPTH) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full: got level=%0d ready=%b expected %0d/0", level, in_ready, DEPTH);
        end
        in_op = 3'd3; in_rd = 5'd9; in_rs1 = 5'd10; in_imm = 12'h5A5;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (level !== LW'(DEPTH - 1) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop: got level=%0d ready=%b expected %0d/1", level, in_ready,
                     DEPTH - 1);
        end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'b1;
            in_op     = 3'($urandom_range(0, 7));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_imm    = 12'($urandom);
            out_ready = (i < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    task automatic test_err_sat();
        in_valid  = 1'b1;
        in_op     = 3'd7;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (err_count !== 8'd255 || level !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sat: got c=%0d l=%0d v=%b expected 255/0/0", err_count, level,
                     out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op = 3'd1; in_rd = 5'(i); in_rs1 = 5'(i + 1); in_rs2 = 5'(i + 2);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b1 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b l=%0d r=%b c=%0d expected 0/0/1/0", out_valid,
                     level, in_ready, err_count);
        end
        sb_q.delete();
        cnt_m   = 0;
        err_exp = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd0; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd3;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_instr !== 32'h003100B3) begin
            n_fail++;
            $display("FAIL rst_add: got %b/%h expected 1/003100b3", out_valid, out_instr);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_encodings();
        test_full();
        test_back_to_back();
        test_err_sat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes decoded operation fields back into 32-bit RV32 instruction words: the inverse of the instruction decoder. Sits between the test-program generator / on-chip loader and instruction memory. Accepts one operation per cycle over a valid/ready handshake, buffers encoded words in a small FIFO and presents them on a valid/ready output. Illegal or disabled operations are dropped and counted.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation fields valid.
- in_ready  output  1  encoder can accept (FIFO not full).
- in_op  input  3  0=ADD, 1=SUB, 2=DIV, 3=ADDI, 4=LW, 5=SW, 6..7 illegal.
- in_rd / in_rs1 / in_rs2  input  5 each  register indices.
- in_imm  input  12  immediate (ADDI, LW, SW).
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer takes head word.
- out_instr  output  32  head-of-FIFO instruction word.
- err  output  1  one-cycle pulse when an illegal op is accepted.
- err_count  output  8  saturating count of dropped ops.
- level  output  log2(DEPTH)+1  FIFO occupancy.

## Operation
- Accept when in_valid && in_ready. Encode combinationally from the inputs; write to the FIFO tail on the same edge.
- Encodings (funct7|rs2|rs1|funct3|rd|opcode):
  - ADD: 0000000|rs2|rs1|000|rd|0110011. SUB: 0100000, otherwise the same as ADD.
  - DIV: 0000001|rs2|rs1|100|rd|0110011.
  - ADDI: imm[11:0]|rs1|000|rd|0010011. LW: imm[11:0]|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - Unused fields for an op are ignored; rs2 is ignored for I-type, rd for S-type.
- Illegal op accepted: nothing is written. err pulses high the next cycle. err_count increments and saturates at 255.
- FIFO: read/write pointers of log2(DEPTH)+1 bits. Wrap-around is natural pointer overflow. full = MSBs differ and the rest are equal; empty = pointers equal.
- in_ready = !full, even when the op is illegal.
- Pop when out_valid && out_ready. out_instr = mem[rd_ptr]. out_instr holds stable while out_valid && !out_ready.
- Simultaneous push and pop when not full and not empty: both occur and level is unchanged.
- Full: in_ready is low and the same-cycle pop does not open a slot. in_ready rises the cycle after the pop.
- Empty: pop is ignored. There is no bypass path.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, err=0, err_count=0, level=0. Pointers are 0; FIFO contents are don't-care.
- Reset asserted mid-stream: the FIFO is flushed immediately (asynchronous). Words in flight are lost. The first accept after deassertion behaves as from reset.
- Latency: op accepted at edge N gives out_valid=1 with the word after edge N, when the FIFO was empty.
- Throughput: 1 op/cycle sustained while out_ready=1.
- err is asserted for exactly one cycle per illegal accept. Back-to-back illegal ops keep err high continuously.

## Configuration
- ENC_DIV_EN defined: op 2 encodes DIV as above.
- ENC_DIV_EN undefined: op 2 is treated as illegal (dropped, err, counted). No DIV encoding logic is generated.

## Test plan
- ADD rd=1, rs1=2, rs2=3 -> out_instr=0x003100B3 one cycle later. SUB with the same fields -> 0x403100B3.
- ADDI rd=5, rs1=0, imm=0xFFF -> 0xFFF00293. LW rd=1, rs1=2, imm=4 -> 0x00412083. SW rs2=6, rs1=2, imm=8 -> 0x00612423.
- DIV rd=1, rs1=2, rs2=3:
  - With ENC_DIV_EN -> 0x023140B3.
  - Without ENC_DIV_EN -> no output, err pulses, err_count=1.
- Push 4 ops with out_ready=0 -> level=4 and in_ready=0. Present a 5th op with out_ready=1 -> no accept that cycle. Accepted next cycle; outputs drain in order with no loss.
- Send 300 op=7 -> err_count=255 saturated, FIFO stays empty.
- Fill 3 entries, assert rst for 1 cycle mid-transfer -> out_valid=0, level=0 immediately. The next ADD emerges correctly.
